alu_seq: RTL
============

# alu_seq

Parametrised, multi-cycle successor to the 8-bit datapath ALU. Accepts one operation per valid/ready handshake, executes single-cycle ops (add/sub/nand/xor) in one cycle and iterative ops (shifts, optional multiply) one bit per cycle, then holds a registered result plus a four-bit flags word until the consumer accepts it. Sits between register-file read and writeback in the CPU core, sharing the control unit's immediate-select scheme.

## Interface
- `WIDTH`, 8, datapath width in bits (≥4).
- `IMM_W`, 2, immediate width from the control unit (≤ `WIDTH`).
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `in_valid` in 1: operation request.
- `in_ready` out 1: block can accept an operation.
- `src1` in `WIDTH`: first operand.
- `src2` in `WIDTH`: second operand when `imm_sel`=0.
- `imm` in `IMM_W`: immediate, zero-extended to `WIDTH`.
- `imm_sel` in 1: 1 selects `imm`, 0 selects `src2`.
- `alu_op` in 3: 000 ADD, 001 SUB, 010 NAND, 011 NULL, 100 SHL, 101 SHR (logical), 110 MUL, 111 XOR.
- `out_valid` out 1: result and flags valid.
- `out_ready` in 1: consumer accepts result.
- `result` out `WIDTH`: registered result.
- `flags` out 4: {N, V, C, Z}, registered.

## Operation
- op2 = `imm_sel` ? zero-extend(`imm`) : `src2`, captured with `src1` and `alu_op` at accept.
- FSM states IDLE, EXEC, DONE. `in_ready` = 1 only in IDLE; `out_valid` = 1 only in DONE.
- IDLE: on `in_valid`&&`in_ready`: ADD/SUB/NAND/XOR/NULL → DONE with result computed; SHL/SHR with amount 0 → DONE (result = `src1`); SHL/SHR with amount >0 and MUL → EXEC.
- Shift amount = min(op2, `WIDTH`). EXEC shifts one bit per cycle, decrementing a counter; → DONE when counter reaches 0.
- MUL: shift-add over `WIDTH` EXEC cycles, 2·`WIDTH` product; `result` = low half.
- DONE: hold `result`/`flags` stable; on `out_ready` → IDLE. No accept in the same cycle as output handoff.
- Arithmetic: modulo 2^`WIDTH`.
- Flags, updated on entry to DONE, except NULL which forces result 0 and leaves `flags` unchanged:
  - Z = (result == 0).
  - N = result[`WIDTH`-1].
  - C: ADD carry-out; SUB borrow (`src1` < op2 unsigned); shifts last bit shifted out (0 if amount 0); MUL 1 if high half ≠ 0; NAND/XOR 0.
  - V: signed overflow for ADD/SUB; 0 otherwise.
- `in_valid` ignored outside IDLE; operands not re-sampled after accept.

## Timing
- Reset (async assert, any state incl. mid-EXEC): state IDLE, `in_ready`=1, `out_valid`=0, `result`=0, `flags`=0, counters 0. Deassertion is synchronised externally.
- Accept at edge T: single-cycle ops and zero shifts have `out_valid`=1 after edge T.
- Shift by n (1..`WIDTH`): `out_valid` after edge T+n.
- MUL: `out_valid` after edge T+`WIDTH`.
- Handoff at edge D (`out_valid`&&`out_ready`): `in_ready`=1 after D; next accept earliest at D+1. Peak throughput one op per 2 cycles.
- `out_ready` low: output held indefinitely, no change to `result`/`flags`.

## Configuration
- `ALU_SEQ_MUL_EN` defined: MUL implemented as above (product register, `WIDTH`-cycle EXEC).
- Undefined: no multiplier hardware; op 110 behaves exactly as NULL (result 0, flags unchanged, one-cycle latency).

## Test plan
- ADD `src1`=0xFF, `src2`=0x01 → `result`=0x00, flags N0 V0 C1 Z1, `out_valid` after accept edge.
- SUB `src1`=0x80, `imm`=2'b01, `imm_sel`=1 → `result`=0x7F, N0 V1 C0 Z0.
- SHL `src1`=0x81 by 3 → `out_valid` 3 edges after accept, `result`=0x08, C0; SHR 0x81 by 1 → 0x40, C1.
- MUL 0x10×0x11 (macro defined) → `result`=0x10, C1, `out_valid` 8 edges after accept; macro undefined → `result`=0x00, flags equal previous op's flags, 1-cycle latency.
- Backpressure: hold `out_ready`=0 for 5 cycles after ADD 0x03+0x04 → `result`=0x07 stable, `in_ready`=0, new `in_valid` ignored; then NULL → `result`=0, flags unchanged.
- Assert `rst_n`=0 at 4th EXEC cycle of MUL → immediately `result`=0, `flags`=0, `out_valid`=0, `in_ready`=1; next ADD 0x01+0x01 yields 0x02.

Source files
------------

// File: rtl/alu_seq.sv
// alu_seq: multi-cycle ALU, valid/ready in and out, registered result/flags {N,V,C,Z}.
// Ports: clk, rst_n, in_valid/in_ready, src1, src2, imm, imm_sel, alu_op,
//   out_valid/out_ready, result, flags. ALU_SEQ_MUL_EN enables the multiplier.
module alu_seq #(
  parameter int WIDTH = 8,
  parameter int IMM_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  input  logic [IMM_W-1:0] imm,
  input  logic             imm_sel,
  input  logic [2:0]       alu_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] W_OP = WIDTH'(WIDTH);

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_NAND = 3'b010;
  localparam logic [2:0] OP_SHL  = 3'b100;
  localparam logic [2:0] OP_SHR  = 3'b101;
  localparam logic [2:0] OP_XOR  = 3'b111;
`ifdef ALU_SEQ_MUL_EN
  localparam logic [2:0] OP_MUL  = 3'b110;
`endif

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    DONE
  } state_t;

  state_t state;

  logic [WIDTH-1:0] a_q;
  logic [2:0]       op_q;
  logic [CW-1:0]    cnt;

  logic [WIDTH-1:0] op2;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic             v_add;
  logic             v_sub;
  logic [WIDTH-1:0] nand_r;
  logic [WIDTH-1:0] xor_r;
  logic [CW-1:0]    sh_amt;
  logic [WIDTH-1:0] sh_next;
  logic             sh_out;

  function automatic logic [3:0] mk_flags(
    input logic [WIDTH-1:0] r,
    input logic             v,
    input logic             c
  );
    return {r[WIDTH-1], v, c, (r == '0)};
  endfunction

  assign op2    = imm_sel ? WIDTH'(imm) : src2;
  assign sum    = {1'b0, src1} + {1'b0, op2};
  assign diff   = {1'b0, src1} - {1'b0, op2};
  assign v_add  = (src1[WIDTH-1] == op2[WIDTH-1]) &&
                  (sum[WIDTH-1] != src1[WIDTH-1]);
  assign v_sub  = (src1[WIDTH-1] != op2[WIDTH-1]) &&
                  (diff[WIDTH-1] != src1[WIDTH-1]);
  assign nand_r = ~(src1 & op2);
  assign xor_r  = src1 ^ op2;
  assign sh_amt = (op2 > W_OP) ? CW'(WIDTH) : CW'(op2);

  // One-bit shift step and the bit it pushes out.
  assign sh_next = (op_q == OP_SHR) ? (a_q >> 1) : (a_q << 1);
  assign sh_out  = (op_q == OP_SHR) ? a_q[0] : a_q[WIDTH-1];

`ifdef ALU_SEQ_MUL_EN
  // Shift-add: upper half accumulates, multiplier drains from the bottom.
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH:0]     madd;
  logic [2*WIDTH-1:0] mul_next;

  assign madd     = {1'b0, prod[2*WIDTH-1:WIDTH]} +
                    (prod[0] ? {1'b0, a_q} : '0);
  assign mul_next = {madd, prod[WIDTH-1:1]};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      result    <= '0;
      flags     <= '0;
      a_q       <= '0;
      op_q      <= '0;
      cnt       <= '0;
`ifdef ALU_SEQ_MUL_EN
      prod      <= '0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            op_q      <= alu_op;
            a_q       <= src1;
            state     <= DONE;
            in_ready  <= 1'b0;
            out_valid <= 1'b1;
            unique case (alu_op)
              OP_ADD: begin
                result <= sum[WIDTH-1:0];
                flags  <= mk_flags(sum[WIDTH-1:0], v_add, sum[WIDTH]);
              end
              OP_SUB: begin
                result <= diff[WIDTH-1:0];
                flags  <= mk_flags(diff[WIDTH-1:0], v_sub, diff[WIDTH]);
              end
              OP_NAND: begin
                result <= nand_r;
                flags  <= mk_flags(nand_r, 1'b0, 1'b0);
              end
              OP_XOR: begin
                result <= xor_r;
                flags  <= mk_flags(xor_r, 1'b0, 1'b0);
              end
              OP_SHL, OP_SHR: begin
                if (sh_amt == '0) begin
                  result <= src1;
                  flags  <= mk_flags(src1, 1'b0, 1'b0);
                end else begin
                  cnt       <= sh_amt;
                  state     <= EXEC;
                  out_valid <= 1'b0;
                end
              end
`ifdef ALU_SEQ_MUL_EN
              OP_MUL: begin
                prod      <= {{WIDTH{1'b0}}, op2};
                cnt       <= CW'(WIDTH);
                state     <= EXEC;
                out_valid <= 1'b0;
              end
`endif
              default: begin
                // NULL: zero result, flags left alone.
                result <= '0;
              end
            endcase
          end
        end
        EXEC: begin
          cnt <= cnt - CW'(1);
`ifdef ALU_SEQ_MUL_EN
          if (op_q == OP_MUL) begin
            prod <= mul_next;
            if (cnt == CW'(1)) begin
              result    <= mul_next[WIDTH-1:0];
              flags     <= mk_flags(mul_next[WIDTH-1:0], 1'b0,
                                    mul_next[2*WIDTH-1:WIDTH] != '0);
              state     <= DONE;
              out_valid <= 1'b1;
            end
          end else begin
`endif
            a_q <= sh_next;
            if (cnt == CW'(1)) begin
              result    <= sh_next;
              flags     <= mk_flags(sh_next, 1'b0, sh_out);
              state     <= DONE;
              out_valid <= 1'b1;
            end
`ifdef ALU_SEQ_MUL_EN
          end
`endif
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule
